// File: rtl/sw_pkg.sv
// sw_pkg: shared sizes, base codes, FSM states and saturating score helpers
package sw_pkg;
  localparam int PE_Array_size = 8;
  localparam int PE_Array_size_log = 3;
  localparam int Sram_Addr = 512;
  localparam int V_E_F_Bit = 12;
  localparam int T_MAX = Sram_Addr * 7;
  localparam logic [1:0] BASE_A = 2'd0;
  localparam logic [1:0] BASE_C = 2'd1;
  localparam logic [1:0] BASE_G = 2'd2;
  localparam logic [1:0] BASE_T = 2'd3;
  typedef enum logic [2:0] {IDLE, LOAD_T, REQ, WAIT_S, RUN, DONE} state_t;
  typedef logic [V_E_F_Bit-1:0] score_t;
  function automatic score_t sub0(score_t a, score_t b);
    return a > b ? a - b : '0;
  endfunction
  function automatic score_t addsat(score_t a, score_t b);
    logic [V_E_F_Bit:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[V_E_F_Bit] ? '1 : s[V_E_F_Bit-1:0];
  endfunction
  function automatic score_t smax(score_t a, score_t b);
    return a > b ? a : b;
  endfunction
endpackage

// File: rtl/sw_pe.sv
// sw_pe: one systolic cell holding a single S base; T bases stream through left to right
module sw_pe
  import sw_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_clr,
  input  logic       i_mclr,
  input  logic       i_v,
  input  logic       i_act,
  input  logic [1:0] i_sb,
  input  logic [1:0] i_t,
  input  score_t     i_h,
  input  score_t     i_f,
  input  score_t     i_match,
  input  score_t     i_mismatch,
  input  score_t     i_alpha,
  input  score_t     i_beta,
  output logic       o_v,
  output logic [1:0] o_t,
  output score_t     o_h,
  output score_t     o_f,
  output score_t     o_mx
);
  score_t h_q, h_d, e_q, e_d, f_q, f_d, d_q, d_d, mx_q, mx_d, e_c, f_c, h_c;
  logic v_q, v_d;
  logic [1:0] t_q, t_d;
  // h_q/e_q are the left neighbour (previous T column); d_q is the upstream H one column back
  always_comb begin
    e_c = smax(sub0(h_q, i_alpha), sub0(e_q, i_beta));
    f_c = smax(sub0(i_h, i_alpha), sub0(i_f, i_beta));
    h_c = smax(smax(e_c, f_c), i_t == i_sb ? addsat(d_q, i_match) : sub0(d_q, i_mismatch));
    h_d = i_clr ? '0 : i_v ? h_c : h_q;
    e_d = i_clr ? '0 : i_v ? e_c : e_q;
    f_d = i_clr ? '0 : i_v ? f_c : f_q;
    d_d = i_clr ? '0 : i_h;
    v_d = !i_clr && i_v;
    t_d = i_t;
    mx_d = i_mclr ? '0 : (i_v && i_act) ? smax(mx_q, h_c) : mx_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_q <= '0;
      e_q <= '0;
      f_q <= '0;
      d_q <= '0;
      v_q <= 1'b0;
      t_q <= '0;
      mx_q <= '0;
    end else begin
      h_q <= h_d;
      e_q <= e_d;
      f_q <= f_d;
      d_q <= d_d;
      v_q <= v_d;
      t_q <= t_d;
      mx_q <= mx_d;
    end
  end
  assign o_v = v_q;
  assign o_t = t_q;
  assign o_h = h_q;
  assign o_f = f_q;
  assign o_mx = mx_q;
endmodule

// File: rtl/top.sv
// top: Smith-Waterman affine-gap accelerator; T memory, chunked S over a PE array, strip buffer
module top
  import sw_pkg::*;
(
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         i_set_t,
  input  logic [17:0]                  i_t,
  input  logic                         i_start_cal,
  input  logic                         i_param_valid,
  input  logic [3:0]                   i_match,
  input  logic [3:0]                   i_mismatch,
  input  logic [7:0]                   i_minusAlpha,
  input  logic [7:0]                   i_minusBeta,
  output logic                         o_request_s,
  input  logic [2*PE_Array_size-1:0]   i_s,
  input  logic [PE_Array_size_log:0]   i_s_valid,
  output logic                         o_busy,
  output logic                         o_valid,
  output logic [V_E_F_Bit-1:0]         o_result
);
  localparam int N = PE_Array_size;
  state_t st_q, st_d;
  logic [11:0] c_q, c_d, len_q, len_d;
  logic [8:0] rw_q, rw_d, wa_q, wa_d;
  logic [2:0] bi_q, bi_d, inc;
  logic [PE_Array_size_log:0] sv_q, sv_d;
  logic [2*N-1:0] s_q, s_d;
  logic last_q, last_d, first_q, first_d;
  logic [3:0] ma_q, ma_d, mm_q, mm_d;
  logic [7:0] al_q, al_d, be_q, be_d;
  logic [13:0] tmem [Sram_Addr];
  score_t bh [T_MAX];
  score_t bf [T_MAX];
  logic set, start, pv, we, feed, drain, clr, unused;
  logic v_a [N+1];
  logic [1:0] t_a [N+1];
  score_t h_a [N+1], f_a [N+1], mx_a [N];
  score_t mx, ma_x, mm_x, al_x, be_x;
  assign set = st_q == IDLE && i_set_t;
  assign start = st_q == IDLE && !i_set_t && i_start_cal;
  assign pv = st_q == IDLE && i_param_valid;
  assign we = set || st_q == LOAD_T;
  assign inc = i_t[16:14] != 3'd0 ? i_t[16:14] : 3'd7;
  assign feed = st_q == RUN && c_q < len_q;
  assign drain = st_q == RUN && c_q == len_q + 12'd7;
  assign clr = st_q == WAIT_S;
  always_comb begin
    st_d = st_q;
    case (st_q)
      IDLE:    st_d = i_set_t ? (i_t[16:14] != 3'd0 ? IDLE : LOAD_T) : i_start_cal ? REQ : IDLE;
      LOAD_T:  st_d = i_t[16:14] != 3'd0 ? IDLE : LOAD_T;
      REQ:     st_d = WAIT_S;
      WAIT_S:  st_d = i_s_valid == '0 ? DONE : RUN;
      RUN:     st_d = drain ? (last_q ? DONE : REQ) : RUN;
      DONE:    st_d = IDLE;
      default: st_d = IDLE;
    endcase
  end
  always_comb begin
    len_d = set ? {9'd0, inc} : st_q == LOAD_T ? len_q + {9'd0, inc} : len_q;
    wa_d = set ? 9'd1 : st_q == LOAD_T ? wa_q + 9'd1 : wa_q;
    c_d = clr ? '0 : st_q == RUN ? c_q + 12'd1 : c_q;
    bi_d = clr ? '0 : feed ? (bi_q == 3'd6 ? 3'd0 : bi_q + 3'd1) : bi_q;
    rw_d = clr ? '0 : (feed && bi_q == 3'd6) ? rw_q + 9'd1 : rw_q;
    first_d = start ? 1'b1 : drain ? 1'b0 : first_q;
    s_d = clr ? i_s : s_q;
    sv_d = clr ? i_s_valid : sv_q;
    last_d = clr ? !i_s_valid[PE_Array_size_log] : last_q;
    ma_d = pv ? i_match : ma_q;
    mm_d = pv ? i_mismatch : mm_q;
    al_d = pv ? i_minusAlpha : al_q;
    be_d = pv ? i_minusBeta : be_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q <= IDLE;
      c_q <= '0;
      len_q <= '0;
      rw_q <= '0;
      wa_q <= '0;
      bi_q <= '0;
      sv_q <= '0;
      s_q <= '0;
      last_q <= 1'b0;
      first_q <= 1'b0;
      ma_q <= '0;
      mm_q <= '0;
      al_q <= '0;
      be_q <= '0;
    end else begin
      st_q <= st_d;
      c_q <= c_d;
      len_q <= len_d;
      rw_q <= rw_d;
      wa_q <= wa_d;
      bi_q <= bi_d;
      sv_q <= sv_d;
      s_q <= s_d;
      last_q <= last_d;
      first_q <= first_d;
      ma_q <= ma_d;
      mm_q <= mm_d;
      al_q <= al_d;
      be_q <= be_d;
    end
  end
  // the last PE's H/F for column c-8 emerges now; it seeds PE0 of the next strip
  always_ff @(posedge clk) begin
    if (we) tmem[set ? 9'd0 : wa_q] <= i_t[13:0];
    if (v_a[N]) begin
      bh[c_q - 12'd8] <= h_a[N];
      bf[c_q - 12'd8] <= f_a[N];
    end
  end
  assign ma_x = score_t'(ma_q);
  assign mm_x = score_t'(mm_q);
  assign al_x = score_t'(al_q);
  assign be_x = score_t'(be_q);
  assign v_a[0] = feed;
  assign t_a[0] = tmem[rw_q][{bi_q, 1'b0} +: 2];
  assign h_a[0] = (first_q || !feed) ? '0 : bh[c_q];
  assign f_a[0] = (first_q || !feed) ? '0 : bf[c_q];
  for (genvar k = 0; k < N; k++) begin : g_pe
    localparam logic [PE_Array_size_log:0] K = k;
    sw_pe u_pe (
      .clk(clk), .rst_n(rst_n), .i_clr(clr), .i_mclr(start),
      .i_v(v_a[k]), .i_act(sv_q > K), .i_sb(s_q[2*k +: 2]), .i_t(t_a[k]),
      .i_h(h_a[k]), .i_f(f_a[k]), .i_match(ma_x), .i_mismatch(mm_x),
      .i_alpha(al_x), .i_beta(be_x), .o_v(v_a[k+1]), .o_t(t_a[k+1]),
      .o_h(h_a[k+1]), .o_f(f_a[k+1]), .o_mx(mx_a[k])
    );
  end
  always_comb begin
    mx = '0;
    for (int k = 0; k < N; k++) mx = smax(mx, mx_a[k]);
  end
  assign unused = ^{i_t[17], t_a[N]};
  assign o_busy = st_q == LOAD_T || st_q == REQ || st_q == WAIT_S || st_q == RUN;
  assign o_request_s = st_q == REQ;
  assign o_valid = st_q == DONE;
  assign o_result = st_q == DONE ? mx : '0;
endmodule

// File: tb/tb_top.sv
// tb_top: randomized and directed checks of top against a full-matrix Smith-Waterman model
module tb_top;
  logic clk = 0, rst_n = 0, i_set_t = 0, i_start_cal = 0, i_param_valid = 0;
  logic [17:0] i_t = '0;
  logic [3:0] i_match = '0, i_mismatch = '0;
  logic [7:0] i_minusAlpha = '0, i_minusBeta = '0;
  logic [15:0] i_s = '0;
  logic [3:0] i_s_valid = '0;
  logic o_request_s, o_busy, o_valid;
  logic [11:0] o_result;
  int n_chk = 0, n_err = 0;
  logic [1:0] tt [64];
  logic [1:0] ss [64];
  int nt, ns;

  top dut (
    .clk(clk), .rst_n(rst_n), .i_set_t(i_set_t), .i_t(i_t), .i_start_cal(i_start_cal),
    .i_param_valid(i_param_valid), .i_match(i_match), .i_mismatch(i_mismatch),
    .i_minusAlpha(i_minusAlpha), .i_minusBeta(i_minusBeta), .o_request_s(o_request_s),
    .i_s(i_s), .i_s_valid(i_s_valid), .o_busy(o_busy), .o_valid(o_valid), .o_result(o_result)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int fl(int x, int y);
    return x > y ? x - y : 0;
  endfunction

  function automatic int mx2(int x, int y);
    return x > y ? x : y;
  endfunction

  function automatic int model(int m, int mm, int a, int b);
    int h [65][65];
    int e [65][65];
    int f [65][65];
    int best, dg;
    best = 0;
    for (int i = 0; i <= ns; i++)
      for (int j = 0; j <= nt; j++) begin
        h[i][j] = 0; e[i][j] = 0; f[i][j] = 0;
        if (i > 0 && j > 0) begin
          e[i][j] = mx2(fl(h[i][j-1], a), fl(e[i][j-1], b));
          f[i][j] = mx2(fl(h[i-1][j], a), fl(f[i-1][j], b));
          dg = (tt[j-1] == ss[i-1]) ? h[i-1][j-1] + m : fl(h[i-1][j-1], mm);
          if (dg > 4095) dg = 4095;
          h[i][j] = mx2(mx2(e[i][j], f[i][j]), dg);
          best = mx2(best, h[i][j]);
        end
      end
    return best;
  endfunction

  function automatic logic [1:0] code(byte c);
    return c == "A" ? 2'd0 : c == "C" ? 2'd1 : c == "G" ? 2'd2 : 2'd3;
  endfunction

  task automatic set_seq(input string t, input string s);
    nt = t.len();
    ns = s.len();
    for (int i = 0; i < nt; i++) tt[i] = code(t[i]);
    for (int i = 0; i < ns; i++) ss[i] = code(s[i]);
  endtask

  task automatic load_t();
    int w;
    logic [17:0] word;
    w = (nt + 6) / 7;
    for (int i = 0; i < w; i++) begin
      word = '0;
      for (int k = 0; k < 7; k++) if (7 * i + k < nt) word[2*k +: 2] = tt[7*i+k];
      if (i == w - 1) word[16:14] = 3'(nt - 7 * i);
      @(negedge clk);
      i_set_t = (i == 0);
      i_t = word;
    end
    @(negedge clk);
    i_set_t = 0;
    i_t = '0;
  endtask

  task automatic run(input int m, input int mm, input int a, input int b, input int inj,
                     output int res);
    int pos, k;
    bit got;
    pos = 0; got = 0; res = -1;
    @(negedge clk);
    i_match = 4'(m); i_mismatch = 4'(mm); i_minusAlpha = 8'(a); i_minusBeta = 8'(b);
    i_param_valid = 1; i_start_cal = 1;
    @(negedge clk);
    i_param_valid = 0; i_start_cal = 0;
    for (int cyc = 0; cyc < 5000 && !got; cyc++) begin
      if (cyc == inj) begin
        check("busy_at_inject", o_busy, 1);
        i_set_t = 1; i_start_cal = 1; i_t = 18'h3ffff;
      end
      if (o_valid) begin
        got = 1;
        res = o_result;
      end else if (o_request_s) begin
        k = ns - pos;
        if (k > 8) k = 8;
        i_s = '0;
        for (int q = 0; q < k; q++) i_s[2*q +: 2] = ss[pos+q];
        i_s_valid = 4'(k);
        pos += k;
      end
      if (!got) begin
        @(negedge clk);
        i_set_t = 0; i_start_cal = 0; i_t = '0;
      end
    end
    check("done_seen", got, 1);
    @(negedge clk);
    check("valid_pulse", o_valid, 0);
    check("busy_after", o_busy, 0);
  endtask

  int r;

  initial begin
    repeat (3) @(negedge clk);
    check("rst_busy", o_busy, 0);
    check("rst_valid", o_valid, 0);
    check("rst_result", o_result, 0);
    check("rst_req", o_request_s, 0);
    rst_n = 1;

    set_seq("ACGT", "ACGT");
    load_t(); run(2, 1, 3, 1, -1, r); check("t1_result", r, 8);
    set_seq("ACGT", "TTTT");
    load_t(); run(2, 1, 3, 1, -1, r); check("t2_result", r, 2);
    set_seq("ACGTACGT", "ACGTTACGT");
    load_t(); run(2, 1, 3, 1, -1, r); check("t3_result", r, 13);
    set_seq("ACGT", "");
    load_t(); run(2, 1, 3, 1, -1, r); check("t4_empty_s", r, 0);
    set_seq("ACGTACGT", "ACGTTACGT");
    load_t(); run(2, 1, 3, 1, 6, r); check("t5_ignored_cmds", r, 13);
    run(2, 1, 3, 1, -1, r); check("t5_t_intact", r, 13);

    set_seq("ACGT", "ACGT");
    load_t();
    @(negedge clk);
    i_match = 2; i_mismatch = 1; i_minusAlpha = 3; i_minusBeta = 1;
    i_param_valid = 1; i_start_cal = 1;
    @(negedge clk);
    i_param_valid = 0; i_start_cal = 0;
    for (int cyc = 0; cyc < 20 && !o_request_s; cyc++) @(negedge clk);
    check("t6_req", o_request_s, 1);
    i_s = 16'h00e4; i_s_valid = 4;
    repeat (4) @(negedge clk);
    check("t6_busy_run", o_busy, 1);
    rst_n = 0;
    #1;
    check("t6_rst_busy", o_busy, 0);
    check("t6_rst_valid", o_valid, 0);
    check("t6_rst_result", o_result, 0);
    check("t6_rst_req", o_request_s, 0);
    @(negedge clk);
    rst_n = 1;
    run(2, 1, 3, 1, -1, r); check("t6_empty_t", r, 0);
    load_t(); run(2, 1, 3, 1, -1, r); check("t6_rerun", r, 8);

    for (int it = 0; it < 25; it++) begin
      int m, mm, a, b;
      nt = $urandom_range(1, 40);
      ns = (it % 5 == 0) ? 8 * $urandom_range(1, 3) : $urandom_range(1, 30);
      for (int i = 0; i < nt; i++) tt[i] = 2'($urandom_range(0, 3));
      for (int i = 0; i < ns; i++) ss[i] = (i < nt && $urandom_range(0, 2) != 0) ? tt[i] : 2'($urandom_range(0, 3));
      m = $urandom_range(0, 15); mm = $urandom_range(0, 15);
      a = $urandom_range(0, 20); b = $urandom_range(0, 10);
      load_t();
      run(m, mm, a, b, -1, r);
      check("rand_result", r, model(m, mm, a, b));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end
endmodule
